// File: rtl/spi_xfer_ctrl_if.sv
// Control bundle between the register file / clock generator and the SPI transfer sequencer.
// master drives the request and clock-edge pulses; slave is the sequencer itself.
interface spi_xfer_ctrl_if #(
  parameter int LEN_W = 7,
  parameter int SS_W  = 8
);
  logic             start;
  logic [LEN_W-1:0] char_len;
  logic             tx_negedge;
  logic             rx_negedge;
  logic [SS_W-1:0]  ss_sel;
  logic             auto_ss;
  logic             cpol_0;
  logic             cpol_1;

  logic             go;
  logic             tip;
  logic             lstclk;
  logic             tx_shift;
  logic             rx_sample;
  logic [LEN_W:0]   bit_idx;
  logic [SS_W-1:0]  ss_pad_o;
  logic             busy;
  logic             done;

  modport master (
    output start, char_len, tx_negedge, rx_negedge, ss_sel, auto_ss, cpol_0, cpol_1,
    input  go, tip, lstclk, tx_shift, rx_sample, bit_idx, ss_pad_o, busy, done
  );

  modport slave (
    input  start, char_len, tx_negedge, rx_negedge, ss_sel, auto_ss, cpol_0, cpol_1,
    output go, tip, lstclk, tx_shift, rx_sample, bit_idx, ss_pad_o, busy, done
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI character: go/tip/lstclk to spi_clgen, per-edge shift/sample strobes, slave selects.
// Every output is registered one cycle after its cause; no backpressure, edge pulses outside XFER are dropped.
module spi_xfer_ctrl #(
  parameter int LEN_W = 7,
  parameter int SS_W  = 8
) (
  input  logic          wb_clk,
  input  logic          wb_reset_n,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] CNT_MAX = CNT_ONE << LEN_W;

  state_t          r_state;
  logic [LEN_W:0]  r_tx_cnt;
  logic [LEN_W:0]  r_rx_cnt;
  logic [LEN_W:0]  r_bit_idx;
  logic            r_go;
  logic            r_tip;
  logic            r_lstclk;
  logic            r_tx_shift;
  logic            r_rx_sample;
  logic            r_busy;
  logic            r_done;
  logic [SS_W-1:0] r_ss;

  state_t          w_state_n;
  logic [LEN_W:0]  w_tx_cnt_n;
  logic [LEN_W:0]  w_rx_cnt_n;
  logic [LEN_W:0]  w_bit_idx_n;
  logic            w_go_n;
  logic            w_tip_n;
  logic            w_lstclk_n;
  logic            w_tx_shift_n;
  logic            w_rx_sample_n;
  logic            w_done_n;
  logic [SS_W-1:0] w_ss_n;
  logic [LEN_W:0]  w_len;
  logic            w_tx_edge;
  logic            w_rx_edge;

  // char_len of zero encodes the full 2**LEN_W bit transfer
  assign w_len     = (bus.char_len == '0) ? CNT_MAX : {1'b0, bus.char_len};
  assign w_tx_edge = bus.tx_negedge ? bus.cpol_1 : bus.cpol_0;
  assign w_rx_edge = bus.rx_negedge ? bus.cpol_1 : bus.cpol_0;

  always_ff @(posedge wb_clk or negedge wb_reset_n) begin
    if (!wb_reset_n) begin
      r_state     <= S_IDLE;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_bit_idx   <= '0;
      r_go        <= 1'b0;
      r_tip       <= 1'b0;
      r_lstclk    <= 1'b0;
      r_tx_shift  <= 1'b0;
      r_rx_sample <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ss        <= '1;
    end else begin
      r_state     <= w_state_n;
      r_tx_cnt    <= w_tx_cnt_n;
      r_rx_cnt    <= w_rx_cnt_n;
      r_bit_idx   <= w_bit_idx_n;
      r_go        <= w_go_n;
      r_tip       <= w_tip_n;
      r_lstclk    <= w_lstclk_n;
      r_tx_shift  <= w_tx_shift_n;
      r_rx_sample <= w_rx_sample_n;
      r_busy      <= (w_state_n != S_IDLE);
      r_done      <= w_done_n;
      r_ss        <= w_ss_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_tx_cnt_n    = r_tx_cnt;
    w_rx_cnt_n    = r_rx_cnt;
    w_bit_idx_n   = r_bit_idx;
    w_go_n        = 1'b0;
    w_tip_n       = r_tip;
    w_tx_shift_n  = 1'b0;
    w_rx_sample_n = 1'b0;
    w_done_n      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tip_n = 1'b0;
        if (bus.start) begin
          w_tx_cnt_n  = w_len;
          w_rx_cnt_n  = w_len;
          w_bit_idx_n = '0;
          w_go_n      = 1'b1;
          w_tip_n     = 1'b1;
          w_state_n   = S_XFER;
        end
      end
      S_XFER: begin
        if (w_tx_edge && (r_tx_cnt != '0)) begin
          w_tx_shift_n = 1'b1;
          w_tx_cnt_n   = r_tx_cnt - CNT_ONE;
          w_bit_idx_n  = r_bit_idx + CNT_ONE;
        end
        if (w_rx_edge && (r_rx_cnt != '0)) begin
          w_rx_sample_n = 1'b1;
          w_rx_cnt_n    = r_rx_cnt - CNT_ONE;
        end
        // the last sample strobe is visible for one cycle before done
        if (r_rx_cnt == '0) begin
          w_tip_n   = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        w_tip_n   = 1'b0;
        w_state_n = S_IDLE;
      end
      default: begin
        w_tip_n   = 1'b0;
        w_state_n = S_IDLE;
      end
    endcase

    w_lstclk_n = w_tip_n && (w_tx_cnt_n == CNT_ONE);
    w_ss_n     = bus.auto_ss ? ~(bus.ss_sel & {SS_W{w_tip_n}}) : ~bus.ss_sel;
  end

  assign bus.go        = r_go;
  assign bus.tip       = r_tip;
  assign bus.lstclk    = r_lstclk;
  assign bus.tx_shift  = r_tx_shift;
  assign bus.rx_sample = r_rx_sample;
  assign bus.bit_idx   = r_bit_idx;
  assign bus.ss_pad_o  = r_ss;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
